nav_ctrl: RTL and testbench
===========================

# nav_ctrl

Downstream motion stage of the maze-solver path. Consumes the solver's `strt_hdng`, `strt_mv`, `stp_lft` and `stp_rght` commands and executes each one. A heading change waits for `at_hdng`. A forward move ramps a forward-speed command up, then decelerates on a side-opening or obstacle. Returns a one-cycle `mv_cmplt` to the solver and drives `frwrd_spd`, `moving` and `en_fusion` into the PID/heading stage.

## Interface
- `MAX_FRWRD`, 11'h2A0, saturation ceiling of `frwrd_spd`.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `strt_hdng` input 1: one-cycle pulse; start a heading change.
- `strt_mv` input 1: one-cycle pulse; start a forward move.
- `stp_lft` input 1: level; stop the move at a new left opening.
- `stp_rght` input 1: level; stop the move at a new right opening.
- `hdng_rdy` input 1: one-cycle pulse; new heading sample, paces all speed updates.
- `at_hdng` input 1: level; heading error within tolerance.
- `lft_opn` input 1: level; left side open.
- `rght_opn` input 1: level; right side open.
- `frwrd_opn` input 1: level; path ahead clear (low means obstacle).
- `mv_cmplt` output 1: registered one-cycle pulse; current command finished.
- `moving` output 1: high in every state except IDLE.
- `en_fusion` output 1: high when `frwrd_spd > (MAX_FRWRD >> 1)`; combinational from the speed register.
- `frwrd_spd` output 11: unsigned forward-speed command.

## Operation
- States: IDLE, HEADING, RAMP, DEC_NRM, DEC_FST.
- IDLE:
  - `strt_hdng` → HEADING.
  - Else `strt_mv` → RAMP.
  - Both in the same cycle: heading wins; the move is dropped.
  - `frwrd_spd` holds.
- HEADING:
  - `frwrd_spd` is forced to 0.
  - `at_hdng` sampled high → IDLE, with `mv_cmplt` pulsed.
- RAMP, on each `hdng_rdy`:
  - `frwrd_spd` += INC, saturating at MAX_FRWRD.
- RAMP exits, checked every cycle in this priority order:
  - `!frwrd_opn` → DEC_FST.
  - `stp_lft & lft_rise` → DEC_NRM.
  - `stp_rght & rght_rise` → DEC_NRM.
- Edge detection:
  - `lft_rise = lft_opn & !lft_opn_ff`; `rght_rise` is built the same way.
  - Both edge flops reset to 1, so there is no false edge after reset.
- DEC_NRM, on each `hdng_rdy`:
  - `frwrd_spd` -= 2×INC.
  - `!frwrd_opn` → DEC_FST.
- DEC_FST, on each `hdng_rdy`:
  - `frwrd_spd` -= 4×INC.
- Decrement termination, both DEC states:
  - If `frwrd_spd <= dec`: `frwrd_spd` is set to 0, next state IDLE, `mv_cmplt` pulses.
  - If `frwrd_spd == 0` on DEC entry: terminates on the next cycle without waiting for `hdng_rdy`.
- Ignored inputs:
  - `strt_hdng` and `strt_mv` are ignored outside IDLE.
  - Opening edges are ignored outside RAMP.
- Arithmetic:
  - 11-bit unsigned.
  - Add saturates at MAX_FRWRD; subtract saturates at 0.
  - No wrap-around is ever allowed.

## Timing
- Reset values: state = IDLE; `frwrd_spd` = 0; `mv_cmplt` = 0; `moving` = 0; `en_fusion` = 0; edge flops = 1.
- Start latency:
  - `strt_*` is sampled at edge N.
  - State changes at edge N; `moving` is high from N.
- Speed updates:
  - `frwrd_spd` changes only on an edge where `hdng_rdy` = 1.
  - Exception: HEADING entry, where the speed is cleared at the state change.
- Completion:
  - The terminating condition is sampled at edge N.
  - `mv_cmplt` is high for exactly the cycle after N.
  - `moving` is low from N.
- Reset mid-move: everything returns to the reset values asynchronously. No `mv_cmplt` is issued.

## Configuration
- Macro: `NAV_FAST_SIM_EN`.
- Defined: INC = 11'h018, for short simulations.
- Undefined: INC = 11'h002, for silicon.
- Decrement steps always follow INC: 2×INC for DEC_NRM, 4×INC for DEC_FST.

## Structure
- Package `nav_pkg` holds:
  - the `nav_state_t` enum;
  - INC;
  - DEC_NRM and DEC_FST step constants, selected under the macro.
- Sub-module `nav_spd_ramp` holds:
  - the saturating 11-bit speed register;
  - controls: inc, dec_nrm, dec_fst, clr;
  - the `zero_nxt` flag.

## Test plan
All scenarios run with `NAV_FAST_SIM_EN` defined.
- **Ramp to ceiling.** `strt_mv`, then 30 `hdng_rdy` pulses with `frwrd_opn` = 1 → `frwrd_spd` steps by 0x18 and holds at 0x2A0 from pulse 28. `en_fusion` rises once `frwrd_spd` exceeds 0x150.
- **Left-opening stop.** `stp_lft` = 1 at 0x2A0; `lft_opn` goes 0→1 → DEC_NRM, steps of 0x30. The 14th pulse yields 0, then one `mv_cmplt` cycle and `moving` = 0.
- **Obstacle stop.** `frwrd_opn` drops during DEC_NRM at 0x120 → switches to steps of 0x60. 0x0C0, 0x060, then 0 with `mv_cmplt`.
- **Heading command.** `strt_hdng` while `frwrd_spd` = 0x90 in IDLE → `frwrd_spd` = 0 and `moving` = 1. `at_hdng` high 5 cycles later → single `mv_cmplt`, back to IDLE.
- **Simultaneous start.** `strt_hdng` and `strt_mv` in the same cycle → HEADING entered; no ramp occurs.
- **Reset mid-move.** Assert `rst_n` low at 0x1B0 in RAMP → all outputs 0 immediately. After release, `lft_opn` = 1 with `stp_lft` = 1 does not cause an early stop in the next RAMP.

Source files
------------

// File: rtl/nav_pkg.sv
// nav_pkg: shared types and constants for the nav_ctrl motion stage.
// Build option: define NAV_FAST_SIM_EN to use a large speed increment, which
// shortens simulations. Leave it undefined for the silicon increment.
package nav_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HEADING,
      RAMP,
      DEC_NRM,
      DEC_FST
   } nav_state_t;

   localparam logic [10:0] MAX_FRWRD = 11'h2A0;

`ifdef NAV_FAST_SIM_EN
   localparam logic [10:0] INC = 11'h018;
`else
   localparam logic [10:0] INC = 11'h002;
`endif

   // Braking steps track the ramp increment so decel profiles scale with it.
   localparam logic [10:0] DEC_NRM_STEP = INC << 1;
   localparam logic [10:0] DEC_FST_STEP = INC << 2;

endpackage

// File: rtl/nav_ctrl_if.sv
// nav_ctrl_if: solver commands, sensor levels and motion outputs of nav_ctrl.
// The master side is the solver/sensor environment; the slave is nav_ctrl.
interface nav_ctrl_if;

   logic        strt_hdng;
   logic        strt_mv;
   logic        stp_lft;
   logic        stp_rght;
   logic        hdng_rdy;
   logic        at_hdng;
   logic        lft_opn;
   logic        rght_opn;
   logic        frwrd_opn;
   logic        mv_cmplt;
   logic        moving;
   logic        en_fusion;
   logic [10:0] frwrd_spd;

   modport master (
      output strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy,
             at_hdng, lft_opn, rght_opn, frwrd_opn,
      input  mv_cmplt, moving, en_fusion, frwrd_spd
   );

   modport slave (
      input  strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy,
             at_hdng, lft_opn, rght_opn, frwrd_opn,
      output mv_cmplt, moving, en_fusion, frwrd_spd
   );

endinterface

// File: rtl/nav_spd_ramp.sv
// nav_spd_ramp: saturating 11-bit forward-speed register.
// Adds INC up to MAX_FRWRD, subtracts a braking step down to zero, and flags
// when the value seen after the next edge will be zero.
module nav_spd_ramp
   import nav_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        dec_nrm,
   input  logic        dec_fst,
   input  logic        clr,
   output logic [10:0] spd,
   output logic        zero_nxt
);

   logic [10:0] step;

   // Select the active braking step and predict a zero result.
   always_comb begin
      step     = dec_fst ? DEC_FST_STEP : DEC_NRM_STEP;
      zero_nxt = (spd == '0) | ((dec_nrm | dec_fst) & (spd <= step));
   end

   // Speed register; clear wins, braking beats ramping, both saturate.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of block evaluation order.
      if (!rst_n) begin
         spd <= '0;
      end else if (clr) begin
         spd <= '0;
      end else if (dec_nrm | dec_fst) begin
         spd <= (spd <= step) ? 11'h000 : spd - step;
      end else if (inc) begin
         spd <= (spd >= MAX_FRWRD - INC) ? MAX_FRWRD : spd + INC;
      end
   end

endmodule

// File: rtl/nav_ctrl.sv
// nav_ctrl: executes heading changes and forward moves for the maze solver.
// A move ramps speed on each heading sample, then brakes gently at a new
// side opening or hard at an obstacle; mv_cmplt reports the end of each command.
// Increment size is set by the NAV_FAST_SIM_EN build option in nav_pkg.
module nav_ctrl
   import nav_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   nav_ctrl_if.slave bus
);

   nav_state_t  state;
   logic        lft_opn_ff;
   logic        rght_opn_ff;
   logic        lft_rise;
   logic        rght_rise;
   logic        stop_opening;
   logic        inc;
   logic        dec_nrm;
   logic        dec_fst;
   logic        clr;
   logic        zero_nxt;
   logic [10:0] spd;
   logic        moving_q;
   logic        mv_cmplt_q;

   assign lft_rise     = bus.lft_opn & ~lft_opn_ff;
   assign rght_rise    = bus.rght_opn & ~rght_opn_ff;
   assign stop_opening = (bus.stp_lft & lft_rise) | (bus.stp_rght & rght_rise);

   // Opening history; resets high so an already-open side is not a new edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_opn_ff  <= 1'b1;
         rght_opn_ff <= 1'b1;
      end else begin
         lft_opn_ff  <= bus.lft_opn;
         rght_opn_ff <= bus.rght_opn;
      end
   end

   // Speed-register controls: state selects the action, hdng_rdy paces it.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      inc     = 1'b0;
      dec_nrm = 1'b0;
      dec_fst = 1'b0;
      clr     = 1'b0;
      case (state)
         IDLE:    clr     = bus.strt_hdng;
         HEADING: clr     = 1'b1;
         RAMP:    inc     = bus.hdng_rdy;
         DEC_NRM: dec_nrm = bus.hdng_rdy;
         DEC_FST: dec_fst = bus.hdng_rdy;
         default: clr     = 1'b1;
      endcase
   end

   nav_spd_ramp u_spd_ramp (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc),
      .dec_nrm  (dec_nrm),
      .dec_fst  (dec_fst),
      .clr      (clr),
      .spd      (spd),
      .zero_nxt (zero_nxt)
   );

   // Command sequencer with registered moving and completion outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         moving_q   <= 1'b0;
         mv_cmplt_q <= 1'b0;
      end else begin
         mv_cmplt_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.strt_hdng) begin
                  state    <= HEADING;
                  moving_q <= 1'b1;
               end else if (bus.strt_mv) begin
                  state    <= RAMP;
                  moving_q <= 1'b1;
               end
            end
            HEADING: begin
               if (bus.at_hdng) begin
                  state      <= IDLE;
                  moving_q   <= 1'b0;
                  mv_cmplt_q <= 1'b1;
               end
            end
            RAMP: begin
               if (!bus.frwrd_opn) begin
                  state <= DEC_FST;
               end else if (stop_opening) begin
                  state <= DEC_NRM;
               end
            end
            DEC_NRM: begin
               // Reaching zero ends the move even if an obstacle appears now.
               if (zero_nxt) begin
                  state      <= IDLE;
                  moving_q   <= 1'b0;
                  mv_cmplt_q <= 1'b1;
               end else if (!bus.frwrd_opn) begin
                  state <= DEC_FST;
               end
            end
            DEC_FST: begin
               if (zero_nxt) begin
                  state      <= IDLE;
                  moving_q   <= 1'b0;
                  mv_cmplt_q <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               moving_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.frwrd_spd = spd;
   assign bus.en_fusion = (spd > (MAX_FRWRD >> 1));
   assign bus.moving    = moving_q;
   assign bus.mv_cmplt  = mv_cmplt_q;

endmodule

// File: tb/tb_nav_ctrl.sv
// tb_nav_ctrl: directed and randomized scenarios for nav_ctrl, checked against
// a behavioural model expressed as motion modes and braking rates.
module tb_nav_ctrl;
   import nav_pkg::*;

   localparam int INC_I = int'(INC);
   localparam int MAX_I = int'(MAX_FRWRD);

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   nav_ctrl_if bus ();

   nav_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: mode 0 idle, 1 turning, 2 accelerating, 3 braking at m_rate.
   int m_mode = 0;
   int m_spd  = 0;
   int m_rate = 0;
   bit m_cmplt = 1'b0;
   bit m_lft_prev = 1'b1;
   bit m_rght_prev = 1'b1;

   function automatic void model_next(output int mode, output int spd,
                                      output int rate, output bit cmplt);
      bit lft_new;
      bit rght_new;
      mode     = m_mode;
      spd      = m_spd;
      rate     = m_rate;
      cmplt    = 1'b0;
      lft_new  = bus.lft_opn && !m_lft_prev;
      rght_new = bus.rght_opn && !m_rght_prev;
      case (m_mode)
         0: begin
            if (bus.strt_hdng) begin
               mode = 1;
               spd  = 0;
            end else if (bus.strt_mv) begin
               mode = 2;
            end
         end
         1: if (bus.at_hdng) begin
            mode  = 0;
            cmplt = 1'b1;
         end
         2: begin
            if (bus.hdng_rdy) spd = (m_spd + INC_I > MAX_I) ? MAX_I : m_spd + INC_I;
            if (!bus.frwrd_opn) begin
               mode = 3;
               rate = 4 * INC_I;
            end else if ((bus.stp_lft && lft_new) || (bus.stp_rght && rght_new)) begin
               mode = 3;
               rate = 2 * INC_I;
            end
         end
         3: begin
            if (m_spd == 0 || (bus.hdng_rdy && m_spd <= m_rate)) begin
               spd   = 0;
               mode  = 0;
               cmplt = 1'b1;
            end else begin
               if (bus.hdng_rdy) spd = m_spd - m_rate;
               if (!bus.frwrd_opn) rate = 4 * INC_I;
            end
         end
         default: mode = 0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int nm, ns, nr;
      bit nc;
      if (!rst_n) begin
         m_mode      <= 0;
         m_spd       <= 0;
         m_rate      <= 0;
         m_cmplt     <= 1'b0;
         m_lft_prev  <= 1'b1;
         m_rght_prev <= 1'b1;
      end else begin
         model_next(nm, ns, nr, nc);
         m_mode      <= nm;
         m_spd       <= ns;
         m_rate      <= nr;
         m_cmplt     <= nc;
         m_lft_prev  <= bus.lft_opn;
         m_rght_prev <= bus.rght_opn;
      end
   end

   // Packed {frwrd_spd, moving, mv_cmplt, en_fusion}.
   logic [13:0] obs_v;
   logic [13:0] exp_v;
   assign obs_v = {bus.frwrd_spd, bus.moving, bus.mv_cmplt, bus.en_fusion};
   assign exp_v = {11'(m_spd), m_mode != 0, m_cmplt, m_spd > MAX_I / 2};

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      n_checks++;
      if (obs_v !== 14'h0) begin
         n_errors++;
         $display("FAIL reset_hold: got %h want %h", obs_v, 14'h0);
      end
      rst_n = 1'b1;
      step();
      n_checks++;
      if (obs_v !== 14'h0) begin
         n_errors++;
         $display("FAIL reset_release: got %h want %h", obs_v, 14'h0);
      end
   endtask

   task automatic test_ramp();
      int npulse;
      int e;
      npulse = MAX_I / INC_I + 2;
      bus.strt_mv = 1'b1;
      step();
      bus.strt_mv = 1'b0;
      n_checks++;
      if (bus.moving !== 1'b1 || bus.frwrd_spd !== 11'h0) begin
         n_errors++;
         $display("FAIL ramp_start: got moving=%b spd=%h want 1 000", bus.moving, bus.frwrd_spd);
      end
      for (int p = 1; p <= npulse; p++) begin
         repeat ($urandom_range(2, 0)) begin
            step();
            n_checks++;
            if (obs_v !== exp_v) begin
               n_errors++;
               $display("FAIL ramp_gap: got %h want %h", obs_v, exp_v);
            end
         end
         bus.hdng_rdy = 1'b1;
         step();
         bus.hdng_rdy = 1'b0;
         e = (p * INC_I > MAX_I) ? MAX_I : p * INC_I;
         n_checks++;
         if (bus.frwrd_spd !== 11'(e) || bus.en_fusion !== (e > MAX_I / 2) || obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL ramp_pulse%0d: got spd=%h fus=%b want spd=%h fus=%b", p,
                     bus.frwrd_spd, bus.en_fusion, 11'(e), e > MAX_I / 2);
         end
      end
   endtask

   task automatic test_lft_stop();
      int nstep;
      int e;
      nstep = (MAX_I + 2 * INC_I - 1) / (2 * INC_I);
      bus.stp_lft = 1'b1;
      bus.lft_opn = 1'b1;
      step();
      n_checks++;
      if (bus.frwrd_spd !== MAX_FRWRD || bus.moving !== 1'b1) begin
         n_errors++;
         $display("FAIL lft_entry: got spd=%h moving=%b want %h 1", bus.frwrd_spd, bus.moving, MAX_FRWRD);
      end
      for (int k = 1; k <= nstep; k++) begin
         bus.hdng_rdy = 1'b1;
         step();
         bus.hdng_rdy = 1'b0;
         e = (k == nstep) ? 0 : MAX_I - k * 2 * INC_I;
         n_checks++;
         if (bus.frwrd_spd !== 11'(e) || bus.mv_cmplt !== (k == nstep) ||
             bus.moving !== (k != nstep) || obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL lft_dec%0d: got spd=%h cmplt=%b moving=%b want %h %b %b", k,
                     bus.frwrd_spd, bus.mv_cmplt, bus.moving, 11'(e), k == nstep, k != nstep);
         end
      end
      step();
      n_checks++;
      if (bus.mv_cmplt !== 1'b0 || bus.moving !== 1'b0) begin
         n_errors++;
         $display("FAIL lft_after: got cmplt=%b moving=%b want 0 0", bus.mv_cmplt, bus.moving);
      end
      bus.stp_lft = 1'b0;
      bus.lft_opn = 1'b0;
      step();
   endtask

   task automatic test_obstacle_stop();
      int exp_seq[3];
      exp_seq = '{8 * INC_I, 4 * INC_I, 0};
      bus.strt_mv = 1'b1;
      step();
      bus.strt_mv = 1'b0;
      repeat (16) begin
         bus.hdng_rdy = 1'b1;
         step();
         bus.hdng_rdy = 1'b0;
      end
      bus.stp_rght = 1'b1;
      bus.rght_opn = 1'b1;
      step();
      repeat (2) begin
         bus.hdng_rdy = 1'b1;
         step();
         bus.hdng_rdy = 1'b0;
      end
      n_checks++;
      if (bus.frwrd_spd !== 11'(12 * INC_I) || obs_v !== exp_v) begin
         n_errors++;
         $display("FAIL obst_nrm: got spd=%h want %h", bus.frwrd_spd, 11'(12 * INC_I));
      end
      bus.frwrd_opn = 1'b0;
      step();
      n_checks++;
      if (bus.frwrd_spd !== 11'(12 * INC_I) || bus.moving !== 1'b1) begin
         n_errors++;
         $display("FAIL obst_switch: got spd=%h moving=%b want %h 1", bus.frwrd_spd, bus.moving, 11'(12 * INC_I));
      end
      for (int k = 0; k < 3; k++) begin
         bus.hdng_rdy = 1'b1;
         step();
         bus.hdng_rdy = 1'b0;
         n_checks++;
         if (bus.frwrd_spd !== 11'(exp_seq[k]) || bus.mv_cmplt !== (k == 2) || obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL obst_fst%0d: got spd=%h cmplt=%b want %h %b", k,
                     bus.frwrd_spd, bus.mv_cmplt, 11'(exp_seq[k]), k == 2);
         end
      end
      bus.frwrd_opn = 1'b1;
      bus.stp_rght  = 1'b0;
      bus.rght_opn  = 1'b0;
      step();
   endtask

   task automatic test_heading();
      int n_cmplt;
      n_cmplt = 0;
      bus.strt_hdng = 1'b1;
      bus.hdng_rdy  = 1'b1;
      step();
      bus.strt_hdng = 1'b0;
      bus.hdng_rdy  = 1'b0;
      n_checks++;
      if (bus.frwrd_spd !== 11'h0 || bus.moving !== 1'b1) begin
         n_errors++;
         $display("FAIL hdng_entry: got spd=%h moving=%b want 000 1", bus.frwrd_spd, bus.moving);
      end
      for (int k = 0; k < 4; k++) begin
         bus.strt_mv  = (k == 0);
         bus.hdng_rdy = 1'($urandom_range(1, 0));
         step();
         n_checks++;
         if (obs_v !== exp_v || bus.moving !== 1'b1 || bus.frwrd_spd !== 11'h0) begin
            n_errors++;
            $display("FAIL hdng_wait%0d: got %h want %h", k, obs_v, exp_v);
         end
      end
      bus.strt_mv  = 1'b0;
      bus.hdng_rdy = 1'b0;
      bus.at_hdng  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         bus.at_hdng = 1'b0;
         if (bus.mv_cmplt === 1'b1) n_cmplt++;
      end
      n_checks++;
      if (n_cmplt != 1 || bus.moving !== 1'b0) begin
         n_errors++;
         $display("FAIL hdng_done: got %0d cmplt pulses moving=%b want 1 0", n_cmplt, bus.moving);
      end
   endtask

   task automatic test_simultaneous();
      bus.strt_hdng = 1'b1;
      bus.strt_mv   = 1'b1;
      step();
      bus.strt_hdng = 1'b0;
      bus.strt_mv   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.hdng_rdy = 1'b1;
         step();
         bus.hdng_rdy = 1'b0;
         n_checks++;
         if (bus.frwrd_spd !== 11'h0 || bus.moving !== 1'b1 || obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL simul_%0d: got spd=%h moving=%b want 000 1", k, bus.frwrd_spd, bus.moving);
         end
      end
      bus.at_hdng = 1'b1;
      step();
      bus.at_hdng = 1'b0;
      n_checks++;
      if (bus.mv_cmplt !== 1'b1 || bus.moving !== 1'b0) begin
         n_errors++;
         $display("FAIL simul_done: got cmplt=%b moving=%b want 1 0", bus.mv_cmplt, bus.moving);
      end
      step();
   endtask

   task automatic test_reset_mid_move();
      bus.lft_opn = 1'b1;
      bus.stp_lft = 1'b1;
      step();
      bus.strt_mv = 1'b1;
      step();
      bus.strt_mv = 1'b0;
      repeat (18) begin
         bus.hdng_rdy = 1'b1;
         step();
         bus.hdng_rdy = 1'b0;
      end
      n_checks++;
      if (bus.frwrd_spd !== 11'(18 * INC_I) || obs_v !== exp_v) begin
         n_errors++;
         $display("FAIL rst_pre: got spd=%h want %h", bus.frwrd_spd, 11'(18 * INC_I));
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs_v !== 14'h0) begin
         n_errors++;
         $display("FAIL rst_async: got %h want %h", obs_v, 14'h0);
      end
      step();
      rst_n = 1'b1;
      step();
      n_checks++;
      if (obs_v !== 14'h0) begin
         n_errors++;
         $display("FAIL rst_no_cmplt: got %h want %h", obs_v, 14'h0);
      end
      bus.strt_mv = 1'b1;
      step();
      bus.strt_mv = 1'b0;
      for (int p = 1; p <= 3; p++) begin
         bus.hdng_rdy = 1'b1;
         step();
         bus.hdng_rdy = 1'b0;
         n_checks++;
         if (bus.frwrd_spd !== 11'(p * INC_I) || bus.moving !== 1'b1 || obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL rst_no_false_edge%0d: got spd=%h moving=%b want %h 1", p,
                     bus.frwrd_spd, bus.moving, 11'(p * INC_I));
         end
      end
      bus.frwrd_opn = 1'b0;
      step();
      bus.hdng_rdy = 1'b1;
      step();
      bus.hdng_rdy = 1'b0;
      n_checks++;
      if (bus.frwrd_spd !== 11'h0 || bus.mv_cmplt !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_drain: got spd=%h cmplt=%b want 000 1", bus.frwrd_spd, bus.mv_cmplt);
      end
      bus.frwrd_opn = 1'b1;
      bus.lft_opn   = 1'b0;
      bus.stp_lft   = 1'b0;
      step();
   endtask

   task automatic test_random();
      int guard;
      for (int c = 0; c < 600; c++) begin
         bus.strt_hdng = ($urandom_range(15, 0) == 0);
         bus.strt_mv   = ($urandom_range(7, 0) == 0);
         bus.hdng_rdy  = 1'($urandom_range(1, 0));
         bus.at_hdng   = ($urandom_range(5, 0) == 0);
         bus.stp_lft   = 1'($urandom_range(1, 0));
         bus.stp_rght  = 1'($urandom_range(1, 0));
         if ($urandom_range(4, 0) == 0) bus.lft_opn = ~bus.lft_opn;
         if ($urandom_range(4, 0) == 0) bus.rght_opn = ~bus.rght_opn;
         bus.frwrd_opn = ($urandom_range(19, 0) != 0);
         step();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL random_c%0d: got %h want %h", c, obs_v, exp_v);
         end
      end
      bus.strt_hdng = 1'b0;
      bus.strt_mv   = 1'b0;
      bus.frwrd_opn = 1'b0;
      bus.hdng_rdy  = 1'b1;
      bus.at_hdng   = 1'b1;
      guard = 0;
      while (m_mode != 0 && guard < 2000) begin
         step();
         guard++;
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL random_drain: got %h want %h", obs_v, exp_v);
         end
      end
      n_checks++;
      if (guard >= 2000) begin
         n_errors++;
         $display("FAIL random_timeout: got mode=%0d after %0d cycles want 0", m_mode, guard);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.strt_hdng = 1'b0;
      bus.strt_mv   = 1'b0;
      bus.stp_lft   = 1'b0;
      bus.stp_rght  = 1'b0;
      bus.hdng_rdy  = 1'b0;
      bus.at_hdng   = 1'b0;
      bus.lft_opn   = 1'b0;
      bus.rght_opn  = 1'b0;
      bus.frwrd_opn = 1'b1;
      test_reset();
      test_ramp();
      test_lft_stop();
      test_obstacle_stop();
      test_heading();
      test_simultaneous();
      test_reset_mid_move();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
